pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline hazard controller for the 5-stage RISC-V core. It generates the stall and flush controls for the PC, IF/ID, ID/EX and EX/MEM registers, covering load-use hazards, taken branches and the multi-cycle divider. The divider is sequenced by a small FSM with a fixed-latency counter. The block sits beside the ID/EX register and reads ID-stage operand addresses and EX-stage control bits.

## Interface
Parameters:
- DIV_CYCLES, 32, divider latency in cycles; legal range 2..64.
- CNT_W, 16, width of the stall performance counter.

Ports:
- sys_clk  in  1  clock; all state updates on rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- id_rs_addr_i  in  5  rs1 address of the instruction in ID.
- id_rt_addr_i  in  5  rs2 address of the instruction in ID.
- ex_RegDst_i  in  5  destination register of the instruction in EX.
- ex_MemRead_i  in  1  instruction in EX is a load.
- ex_isdiv_i  in  1  instruction in EX is a divide or remainder.
- branch_taken_i  in  1  branch or jump resolved taken in EX.
- pc_stall_o  out  1  hold PC.
- if_id_stall_o  out  1  hold IF/ID.
- if_id_flush_o  out  1  clear IF/ID.
- id_ex_stall_o  out  1  hold ID/EX.
- id_ex_flush_o  out  1  load a bubble into ID/EX.
- ex_mem_flush_o  out  1  load a bubble into EX/MEM.
- div_start_o  out  1  one-cycle start pulse to the divider.
- div_busy_o  out  1  FSM is in DIV_RUN.
- stall_cnt_o  out  CNT_W  saturating count of cycles with pc_stall_o=1.

## Operation
FSM states:
- IDLE: normal flow.
  - If ex_isdiv_i=1, assert div_start_o, pc_stall_o, if_id_stall_o, id_ex_stall_o and ex_mem_flush_o.
  - Load cnt with DIV_CYCLES-2, then go to DIV_RUN.
- DIV_RUN: assert pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_flush_o and div_busy_o.
  - If cnt==0, go to DIV_DONE; otherwise decrement cnt.
- DIV_DONE: release all stalls so the divide advances to MEM with its result.
  - div_start_o is suppressed even though ex_isdiv_i is still 1.
  - Go to IDLE.

Hazard rules, evaluated in IDLE and DIV_DONE only, in priority order:
- Branch: if branch_taken_i=1, assert if_id_flush_o and id_ex_flush_o. No stall is asserted, and any load-use stall is suppressed.
- Load-use: if ex_MemRead_i=1, ex_RegDst_i!=0 and ex_RegDst_i equals id_rs_addr_i or id_rt_addr_i, assert pc_stall_o and if_id_stall_o, and id_ex_flush_o to insert a bubble.
- Divide start (IDLE only): evaluated with the divide in EX. A taken branch in the same cycle is impossible; if it occurs anyway, the branch wins and the divide is not started.

Other rules:
- In DIV_RUN, branch_taken_i and the load-use inputs are ignored.
- Stall counter: increments by one on each edge where pc_stall_o=1, and holds at all-ones.
- x0 is never a hazard source.

## Timing
- All *_o controls except stall_cnt_o are combinational from the state and the inputs. They are consumed by the pipeline registers at the next edge.
- Registered state: state, cnt (width $clog2(DIV_CYCLES)), stall_cnt_o.
- Reset values, next edge with sys_rst=1: state=IDLE, cnt=0, stall_cnt_o=0.
- While sys_rst=1, every combinational output is forced to 0.
- Reset mid-divide: the FSM returns to IDLE at that edge and no DIV_DONE cycle is produced.
- Divide latency: exactly DIV_CYCLES consecutive stall cycles (the detect cycle plus DIV_CYCLES-1 in DIV_RUN), followed by one DIV_DONE cycle. div_start_o is high in the detect cycle only.
- Load-use costs one stall cycle. The next cycle re-evaluates with the load in MEM, so no stall follows.
- A taken branch costs two bubbles and no stall.
- Back-to-back divides: the second divide enters EX after DIV_DONE, sees IDLE, and starts normally.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - the state enum (IDLE, DIV_RUN, DIV_DONE);
  - the DIV_CYCLES default;
  - the register-address width constant (5).
- One natural sub-module: hazard_detect. It is the purely combinational load-use comparator, instantiated once.
- The FSM, counter and output muxing stay in the top-level module.

## Test plan
- Reset: assert sys_rst for 2 cycles while ex_isdiv_i=1. Required: every output stays 0, stall_cnt_o=0 and state=IDLE.
- Load-use: ex_MemRead_i=1, ex_RegDst_i=5, id_rs_addr_i=5. Required: pc_stall_o, if_id_stall_o and id_ex_flush_o each high for exactly 1 cycle, and stall_cnt_o increments by 1. Repeat with ex_RegDst_i=0: no stall.
- Branch over load-use: branch_taken_i=1 together with a load-use match. Required: if_id_flush_o=1, id_ex_flush_o=1, pc_stall_o=0.
- Divide, DIV_CYCLES=4: ex_isdiv_i=1 held. Required: div_start_o pulses once; stalls are high for 4 cycles and div_busy_o for 3; DIV_DONE has all stalls low; no second div_start_o occurs.
- Reset mid-divide: assert sys_rst in the 2nd DIV_RUN cycle. Required: IDLE at the next edge, all outputs 0, and no DIV_DONE cycle.
- Counter saturation: CNT_W=4, force 20 stall cycles. Required: stall_cnt_o stops at 15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the divider FSM state encoding and the register-address width.
package pipe_ctrl_pkg;

    localparam int DIV_CYCLES_DEF = 32;
    localparam int REG_ADDR_W     = 5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use comparator: a load in EX whose destination feeds
// either ID operand. x0 never counts as a producer.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    output logic                  load_use
);

    always_comb begin
        load_use = ex_mem_read && (ex_rd != '0) &&
                   ((ex_rd == id_rs) || (ex_rd == id_rt));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush generation for the 5-stage core: branch flush, load-use bubble
// and a fixed-latency divider sequencer, plus a saturating stall counter.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int CNT_W      = 16
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic [REG_ADDR_W-1:0] id_rs_addr_i,
    input  logic [REG_ADDR_W-1:0] id_rt_addr_i,
    input  logic [REG_ADDR_W-1:0] ex_RegDst_i,
    input  logic                  ex_MemRead_i,
    input  logic                  ex_isdiv_i,
    input  logic                  branch_taken_i,
    output logic                  pc_stall_o,
    output logic                  if_id_stall_o,
    output logic                  if_id_flush_o,
    output logic                  id_ex_stall_o,
    output logic                  id_ex_flush_o,
    output logic                  ex_mem_flush_o,
    output logic                  div_start_o,
    output logic                  div_busy_o,
    output logic [CNT_W-1:0]      stall_cnt_o
);

    localparam int DIV_CNT_W = $clog2(DIV_CYCLES);
    localparam logic [DIV_CNT_W-1:0] DIV_LOAD = DIV_CNT_W'(DIV_CYCLES - 2);

    state_e               state_q, state_d;
    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
    logic                 load_use;
    logic                 hazard_window;
    logic                 div_go;

    hazard_detect u_hazard_detect (
        .ex_mem_read (ex_MemRead_i),
        .ex_rd       (ex_RegDst_i),
        .id_rs       (id_rs_addr_i),
        .id_rt       (id_rt_addr_i),
        .load_use    (load_use)
    );

    // Branch and load-use only matter outside DIV_RUN; a divide starts only
    // from IDLE and loses to a branch or load-use in the same cycle.
    assign hazard_window = !sys_rst && (state_q != DIV_RUN);
    assign div_go        = !sys_rst && (state_q == IDLE) && ex_isdiv_i &&
                           !branch_taken_i && !load_use;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            stall_cnt_o <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (pc_stall_o && (stall_cnt_o != '1)) begin
                stall_cnt_o <= stall_cnt_o + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (div_go) begin
                    cnt_d   = DIV_LOAD;
                    state_d = DIV_RUN;
                end
            end
            DIV_RUN: begin
                if (cnt_q == '0) begin
                    state_d = DIV_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DIV_DONE: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        pc_stall_o     = 1'b0;
        if_id_stall_o  = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_stall_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        ex_mem_flush_o = 1'b0;
        div_start_o    = 1'b0;
        div_busy_o     = 1'b0;
        if (!sys_rst && (state_q == DIV_RUN)) begin
            pc_stall_o     = 1'b1;
            if_id_stall_o  = 1'b1;
            id_ex_stall_o  = 1'b1;
            ex_mem_flush_o = 1'b1;
            div_busy_o     = 1'b1;
        end else if (hazard_window) begin
            if (branch_taken_i) begin
                if_id_flush_o = 1'b1;
                id_ex_flush_o = 1'b1;
            end else if (load_use) begin
                pc_stall_o    = 1'b1;
                if_id_stall_o = 1'b1;
                id_ex_flush_o = 1'b1;
            end else if (div_go) begin
                div_start_o    = 1'b1;
                pc_stall_o     = 1'b1;
                if_id_stall_o  = 1'b1;
                id_ex_stall_o  = 1'b1;
                ex_mem_flush_o = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with DIV_CYCLES=4 and CNT_W=4.
// Output bits packed as {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
// id_ex_flush, ex_mem_flush, div_start, div_busy}.
module tb_pipe_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    localparam logic [7:0] O_NONE   = 8'b0000_0000;
    localparam logic [7:0] O_LOAD   = 8'b1100_1000;
    localparam logic [7:0] O_BRANCH = 8'b0010_1000;
    localparam logic [7:0] O_START  = 8'b1101_0110;
    localparam logic [7:0] O_RUN    = 8'b1101_0101;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic [4:0] id_rs_addr_i, id_rt_addr_i, ex_RegDst_i;
    logic       ex_MemRead_i, ex_isdiv_i, branch_taken_i;
    logic       pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o;
    logic       id_ex_flush_o, ex_mem_flush_o, div_start_o, div_busy_o;
    logic [3:0] stall_cnt_o;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [3:0] exp_cnt  = '0;
    logic [7:0] outs;

    pipe_hazard_ctrl #(.DIV_CYCLES(4), .CNT_W(4)) dut (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .id_rs_addr_i   (id_rs_addr_i),
        .id_rt_addr_i   (id_rt_addr_i),
        .ex_RegDst_i    (ex_RegDst_i),
        .ex_MemRead_i   (ex_MemRead_i),
        .ex_isdiv_i     (ex_isdiv_i),
        .branch_taken_i (branch_taken_i),
        .pc_stall_o     (pc_stall_o),
        .if_id_stall_o  (if_id_stall_o),
        .if_id_flush_o  (if_id_flush_o),
        .id_ex_stall_o  (id_ex_stall_o),
        .id_ex_flush_o  (id_ex_flush_o),
        .ex_mem_flush_o (ex_mem_flush_o),
        .div_start_o    (div_start_o),
        .div_busy_o     (div_busy_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    always #5 sys_clk = ~sys_clk;

    assign outs = {pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o,
                   id_ex_flush_o, ex_mem_flush_o, div_start_o, div_busy_o};

    // Inputs change 1 ns after the edge; outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        id_rs_addr_i   = '0;
        id_rt_addr_i   = '0;
        ex_RegDst_i    = '0;
        ex_MemRead_i   = 1'b0;
        ex_isdiv_i     = 1'b0;
        branch_taken_i = 1'b0;
    endtask

    task automatic bump();
        if (exp_cnt != 4'hF) exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        sys_rst    = 1'b1;
        ex_isdiv_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            settle();
            n_checks++;
            if (outs !== O_NONE) begin
                n_errors++;
                $display("FAIL reset_outs cyc%0d got %b exp %b", i, outs, O_NONE);
            end
        end
        n_checks++;
        if (stall_cnt_o !== 4'd0) begin
            n_errors++;
            $display("FAIL reset_cnt got %0d exp 0", stall_cnt_o);
        end
        n_checks++;
        if (dut.state_q !== IDLE) begin
            n_errors++;
            $display("FAIL reset_state got %0d exp %0d", dut.state_q, IDLE);
        end
        ex_isdiv_i = 1'b0;
        tick();
        sys_rst = 1'b0;
        settle();
        n_checks++;
        if (outs !== O_NONE) begin
            n_errors++;
            $display("FAIL reset_release got %b exp %b", outs, O_NONE);
        end
        exp_cnt = '0;
    endtask

    task automatic test_load_use();
        // rs match, then rt match; each stalls exactly one cycle
        for (int k = 0; k < 2; k++) begin
            ex_MemRead_i = 1'b1;
            ex_RegDst_i  = (k == 0) ? 5'd5 : 5'd7;
            id_rs_addr_i = (k == 0) ? 5'd5 : 5'd1;
            id_rt_addr_i = (k == 0) ? 5'd2 : 5'd7;
            settle();
            n_checks++;
            if (outs !== O_LOAD) begin
                n_errors++;
                $display("FAIL load_use_stall k%0d got %b exp %b", k, outs, O_LOAD);
            end
            tick();
            bump();
            clear_inputs();
            settle();
            n_checks++;
            if (outs !== O_NONE) begin
                n_errors++;
                $display("FAIL load_use_after k%0d got %b exp %b", k, outs, O_NONE);
            end
            n_checks++;
            if (stall_cnt_o !== exp_cnt) begin
                n_errors++;
                $display("FAIL load_use_cnt k%0d got %0d exp %0d", k, stall_cnt_o, exp_cnt);
            end
        end
        // x0 destination and a plain mismatch are not hazards
        ex_MemRead_i = 1'b1;
        ex_RegDst_i  = 5'd0;
        id_rs_addr_i = 5'd0;
        id_rt_addr_i = 5'd0;
        settle();
        n_checks++;
        if (outs !== O_NONE) begin
            n_errors++;
            $display("FAIL load_use_x0 got %b exp %b", outs, O_NONE);
        end
        ex_RegDst_i  = 5'd3;
        id_rs_addr_i = 5'd4;
        id_rt_addr_i = 5'd6;
        settle();
        n_checks++;
        if (outs !== O_NONE) begin
            n_errors++;
            $display("FAIL load_use_nomatch got %b exp %b", outs, O_NONE);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_branch();
        branch_taken_i = 1'b1;
        ex_MemRead_i   = 1'b1;
        ex_RegDst_i    = 5'd9;
        id_rs_addr_i   = 5'd9;
        settle();
        n_checks++;
        if (outs !== O_BRANCH) begin
            n_errors++;
            $display("FAIL branch_flush got %b exp %b", outs, O_BRANCH);
        end
        tick();
        clear_inputs();
        settle();
        n_checks++;
        if (stall_cnt_o !== exp_cnt) begin
            n_errors++;
            $display("FAIL branch_cnt got %0d exp %0d", stall_cnt_o, exp_cnt);
        end
    endtask

    // One full divide with ex_isdiv_i held: detect, 3 run cycles, done.
    task automatic run_divide(input string tag, input logic branch_in_run);
        ex_isdiv_i = 1'b1;
        settle();
        n_checks++;
        if (outs !== O_START) begin
            n_errors++;
            $display("FAIL %s_start got %b exp %b", tag, outs, O_START);
        end
        tick();
        bump();
        for (int i = 0; i < 3; i++) begin
            branch_taken_i = branch_in_run && (i == 1);
            ex_MemRead_i   = branch_in_run && (i == 2);
            ex_RegDst_i    = 5'd4;
            id_rs_addr_i   = 5'd4;
            settle();
            n_checks++;
            if (outs !== O_RUN || dut.state_q !== DIV_RUN) begin
                n_errors++;
                $display("FAIL %s_run%0d got %b exp %b", tag, i, outs, O_RUN);
            end
            tick();
            bump();
        end
        branch_taken_i = 1'b0;
        ex_MemRead_i   = 1'b0;
        settle();
        n_checks++;
        if (outs !== O_NONE || dut.state_q !== DIV_DONE) begin
            n_errors++;
            $display("FAIL %s_done got %b exp %b", tag, outs, O_NONE);
        end
        n_checks++;
        if (stall_cnt_o !== exp_cnt) begin
            n_errors++;
            $display("FAIL %s_cnt got %0d exp %0d", tag, stall_cnt_o, exp_cnt);
        end
    endtask

    task automatic test_divide();
        run_divide("div", 1'b1);
        tick();
        ex_isdiv_i = 1'b0;
        settle();
        n_checks++;
        if (outs !== O_NONE || dut.state_q !== IDLE) begin
            n_errors++;
            $display("FAIL div_idle got %b exp %b", outs, O_NONE);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        run_divide("b2b_a", 1'b0);
        tick();
        run_divide("b2b_b", 1'b0);
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid_div();
        ex_isdiv_i = 1'b1;
        tick();
        tick();
        sys_rst = 1'b1;
        settle();
        n_checks++;
        if (outs !== O_NONE) begin
            n_errors++;
            $display("FAIL midrst_forced got %b exp %b", outs, O_NONE);
        end
        tick();
        exp_cnt    = '0;
        ex_isdiv_i = 1'b0;
        sys_rst    = 1'b0;
        settle();
        n_checks++;
        if (dut.state_q !== IDLE || outs !== O_NONE || stall_cnt_o !== exp_cnt) begin
            n_errors++;
            $display("FAIL midrst_idle got st%0d %b cnt%0d exp st0 %b cnt0",
                     dut.state_q, outs, stall_cnt_o, O_NONE);
        end
        tick();
        n_checks++;
        if (dut.state_q !== IDLE || outs !== O_NONE) begin
            n_errors++;
            $display("FAIL midrst_no_done got st%0d %b exp st0 %b", dut.state_q, outs, O_NONE);
        end
    endtask

    task automatic test_saturation();
        ex_MemRead_i = 1'b1;
        ex_RegDst_i  = 5'd12;
        id_rt_addr_i = 5'd12;
        for (int i = 0; i < 20; i++) begin
            tick();
            bump();
        end
        settle();
        n_checks++;
        if (stall_cnt_o !== 4'd15 || exp_cnt !== 4'd15) begin
            n_errors++;
            $display("FAIL sat_cnt got %0d exp 15", stall_cnt_o);
        end
        n_checks++;
        if (pc_stall_o !== 1'b1) begin
            n_errors++;
            $display("FAIL sat_stall got %b exp 1", pc_stall_o);
        end
        clear_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_divide();
        test_back_to_back();
        test_reset_mid_div();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
